// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the read and write interconnect halves.
// Response codes, read FSM states and an index-width helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERR
  } rd_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// Maps an address onto one of M slave regions given packed base/size tables.
// Lowest-numbered matching region wins; no match flags a decode error.
module addr_decoder
  import axil_pkg::*;
#(
  parameter int M          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [M*ADDR_WIDTH-1:0] BASE_ADDR_PACKED =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [M*ADDR_WIDTH-1:0] SIZE_PACKED =
    {4{32'h0000_1000}}
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic [idx_w(M)-1:0]    slave_id_o,
  output logic                   valid_o,
  output logic                   decerr_o
);

  localparam int SW = idx_w(M);

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] size;

  // Scan high to low so the lowest matching region overwrites last.
  always_comb begin
    slave_id_o = '0;
    valid_o    = 1'b0;
    base       = '0;
    size       = '0;
    for (int i = M - 1; i >= 0; i--) begin
      base = BASE_ADDR_PACKED[i*ADDR_WIDTH +: ADDR_WIDTH];
      size = SIZE_PACKED[i*ADDR_WIDTH +: ADDR_WIDTH];
      if ((addr_i >= base) && ((addr_i - base) < size)) begin
        slave_id_o = SW'(i);
        valid_o    = 1'b1;
      end
    end
    decerr_o = ~valid_o;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick among N requesters, starting after the last grant.
// Purely combinational; the caller owns the last-grant register.
module rr_arbiter
  import axil_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [idx_w(N)-1:0]  last_grant_i,
  output logic [idx_w(N)-1:0]  grant_o,
  output logic                 any_req_o
);

  localparam int GW = idx_w(N);

  int idx;

  // Walk offsets N..1 so the nearest requester after last_grant wins.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % N;
      if (req_i[idx]) begin
        grant_o   = GW'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// AXI-Lite read path shared by N masters and M slaves, one transaction
// in flight; unmapped addresses are answered locally with DECERR.
module axil_read_arbiter
  import axil_pkg::*;
#(
  parameter int N          = 2,
  parameter int M          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [M*ADDR_WIDTH-1:0] BASE_ADDR_PACKED =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [M*ADDR_WIDTH-1:0] SIZE_PACKED =
    {4{32'h0000_1000}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            m_arvalid,
  input  logic [N*ADDR_WIDTH-1:0] m_araddr,
  output logic [N-1:0]            m_arready,
  output logic [N-1:0]            m_rvalid,
  output logic [N*DATA_WIDTH-1:0] m_rdata,
  output logic [N*2-1:0]          m_rresp,
  input  logic [N-1:0]            m_rready,
  output logic [M-1:0]            s_arvalid,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [M-1:0]            s_arready,
  input  logic [M-1:0]            s_rvalid,
  input  logic [M*DATA_WIDTH-1:0] s_rdata,
  input  logic [M*2-1:0]          s_rresp,
  output logic [M-1:0]            s_rready
);

  localparam int GW = idx_w(N);
  localparam int SW = idx_w(M);

  rd_state_t             state_q, state_d;
  logic [GW-1:0]         last_q, last_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SW-1:0]         sid_q, sid_d;

  logic [GW-1:0]         arb_grant;
  logic                  arb_any;
  logic [ADDR_WIDTH-1:0] ar_sel;
  logic [SW-1:0]         dec_sid;
  logic                  dec_valid;
  logic                  dec_err;

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req_i        (m_arvalid),
    .last_grant_i (last_q),
    .grant_o      (arb_grant),
    .any_req_o    (arb_any)
  );

  assign ar_sel = m_araddr[arb_grant*ADDR_WIDTH +: ADDR_WIDTH];

  addr_decoder #(
    .M                (M),
    .ADDR_WIDTH       (ADDR_WIDTH),
    .BASE_ADDR_PACKED (BASE_ADDR_PACKED),
    .SIZE_PACKED      (SIZE_PACKED)
  ) u_dec (
    .addr_i     (ar_sel),
    .slave_id_o (dec_sid),
    .valid_o    (dec_valid),
    .decerr_o   (dec_err)
  );

  assign s_araddr = addr_q;

  // Next-state and output decode for the single outstanding read.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    sid_d     = sid_q;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_arvalid = '0;
    s_rready  = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          // Held off while reset is asserted so every output is quiet.
          m_arready[arb_grant] = ~rst;
          grant_d = arb_grant;
          addr_d  = ar_sel;
          sid_d   = dec_sid;
          state_d = (dec_valid && !dec_err) ? ADDR : ERR;
        end
      end
      ADDR: begin
        s_arvalid[sid_q] = 1'b1;
        if (s_arready[sid_q]) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_rvalid[grant_q] = s_rvalid[sid_q];
        m_rdata = {N{s_rdata[sid_q*DATA_WIDTH +: DATA_WIDTH]}};
        m_rresp[grant_q*2 +: 2] = s_rresp[sid_q*2 +: 2];
        s_rready[sid_q] = m_rready[grant_q];
        if (s_rvalid[sid_q] && m_rready[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      ERR: begin
        m_rvalid[grant_q] = 1'b1;
        m_rresp[grant_q*2 +: 2] = RESP_DECERR;
        if (m_rready[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers; last grant resets so master 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GW'(N - 1);
      grant_q <= '0;
      addr_q  <= '0;
      sid_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      sid_q   <= sid_d;
    end
  end

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Self-checking bench for axil_read_arbiter with a round-robin and
// address-map reference model driven by directed and random steps.
module tb_axil_read_arbiter;
  import axil_pkg::*;

  localparam int N  = 2;
  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_arvalid;
  logic [N*AW-1:0] m_araddr;
  logic [N-1:0]    m_arready;
  logic [N-1:0]    m_rvalid;
  logic [N*DW-1:0] m_rdata;
  logic [N*2-1:0]  m_rresp;
  logic [N-1:0]    m_rready;
  logic [M-1:0]    s_arvalid;
  logic [AW-1:0]   s_araddr;
  logic [M-1:0]    s_arready;
  logic [M-1:0]    s_rvalid;
  logic [M*DW-1:0] s_rdata;
  logic [M*2-1:0]  s_rresp;
  logic [M-1:0]    s_rready;

  int checks = 0;
  int errors = 0;

  bit          pend  [N];
  logic [31:0] paddr [N];
  int          last_g;
  bit          refill;

  always #5 clk = ~clk;

  axil_read_arbiter #(
    .N (N), .M (M), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_arvalid (m_arvalid),
    .m_araddr  (m_araddr),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rready  (m_rready),
    .s_arvalid (s_arvalid),
    .s_araddr  (s_araddr),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rready  (s_rready)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_m();
    for (int i = 0; i < N; i++) begin
      m_arvalid[i] = pend[i];
      m_araddr[i*AW +: AW] = paddr[i];
    end
  endtask

  // 4 KB regions starting at 0; anything at or above 0x4000 is unmapped.
  function automatic int exp_sid(input logic [31:0] a);
    return (a < 32'h4000) ? int'(a >> 12) : -1;
  endfunction

  // Next pending master after the last one served, with wrap.
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(last_g + k) % N]) return (last_g + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 5))
        0: return 32'h0000_0000;
        1: return 32'h0000_0FFF;
        2: return 32'h0000_1000;
        3: return 32'h0000_3FFF;
        4: return 32'h0000_4000;
        default: return 32'hFFFF_FFFC;
      endcase
    end
    return 32'($urandom_range(0, 32'h4FFF));
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_arready"}, 128'(m_arready), 128'(0));
    chk({tag, "_rvalid"}, 128'(m_rvalid), 128'(0));
    chk({tag, "_rdata"}, 128'(m_rdata), 128'(0));
    chk({tag, "_rresp"}, 128'(m_rresp), 128'(0));
    chk({tag, "_sarvalid"}, 128'(s_arvalid), 128'(0));
    chk({tag, "_saraddr"}, 128'(s_araddr), 128'(0));
    chk({tag, "_srready"}, 128'(s_rready), 128'(0));
  endtask

  // One full read; called at a negedge with the arbiter idle.
  task automatic txn(input int ar_d, input int r_d, input int rr_d);
    int g;
    int sid;
    logic [31:0] a;
    logic [DW-1:0] d;
    logic [1:0] rs;
    g = rr_pick();
    if (g < 0) begin
      chk("no_pending", 128'(0), 128'(1));
      return;
    end
    a = paddr[g];
    sid = exp_sid(a);
    drive_m();
    #1;
    chk("ar_grant", 128'(m_arready), 128'(1) << g);
    @(negedge clk);
    if (refill) paddr[g] = rand_addr();
    else pend[g] = 1'b0;
    drive_m();
    if (sid < 0) begin
      for (int c = 0; c <= rr_d; c++) begin
        m_rready = (c == rr_d) ? N'(1 << g) : '0;
        #1;
        chk("err_rvalid", 128'(m_rvalid), 128'(1) << g);
        chk("err_rdata", 128'(m_rdata), 128'(0));
        chk("err_rresp", 128'(m_rresp), 128'(RESP_DECERR) << (2 * g));
        chk("err_sarvalid", 128'(s_arvalid), 128'(0));
        chk("err_arready", 128'(m_arready), 128'(0));
        @(negedge clk);
      end
      m_rready = '0;
    end else begin
      for (int c = 0; c <= ar_d; c++) begin
        s_arready = (c == ar_d) ? M'(1 << sid) : '0;
        #1;
        chk("addr_sarvalid", 128'(s_arvalid), 128'(1) << sid);
        chk("addr_saraddr", 128'(s_araddr), 128'(a));
        chk("addr_rvalid", 128'(m_rvalid), 128'(0));
        chk("addr_arready", 128'(m_arready), 128'(0));
        @(negedge clk);
      end
      s_arready = '0;
      for (int j = 0; j < M; j++) s_rdata[j*DW +: DW] = $urandom;
      s_rresp = M*2'($urandom);
      d  = s_rdata[sid*DW +: DW];
      rs = s_rresp[sid*2 +: 2];
      for (int c = 0; c < r_d; c++) begin
        #1;
        chk("wait_rvalid", 128'(m_rvalid), 128'(0));
        chk("wait_sarvalid", 128'(s_arvalid), 128'(0));
        @(negedge clk);
      end
      s_rvalid = M'(1 << sid);
      for (int c = 0; c <= rr_d; c++) begin
        m_rready = (c == rr_d) ? N'(1 << g) : '0;
        #1;
        chk("data_rvalid", 128'(m_rvalid), 128'(1) << g);
        chk("data_rdata", 128'(m_rdata), 128'({N{d}}));
        chk("data_rresp", 128'(m_rresp), 128'(rs) << (2 * g));
        chk("data_srready", 128'(s_rready),
            (c == rr_d) ? (128'(1) << sid) : 128'(0));
        chk("data_arready", 128'(m_arready), 128'(0));
        @(negedge clk);
      end
      s_rvalid = '0;
      m_rready = '0;
    end
    last_g = g;
  endtask

  initial begin
    m_arvalid = '0;
    m_araddr  = '0;
    m_rready  = '0;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    refill    = 1'b0;
    last_g    = N - 1;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
    end

    // Reset state, including with requests pending.
    @(negedge clk);
    #1;
    chk_quiet("rst");
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    drive_m();
    #1;
    chk("rst_arready_req", 128'(m_arready), 128'(0));
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_m();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single read into slave 1.
    pend[0]  = 1'b1;
    paddr[0] = 32'h0000_1004;
    txn(0, 0, 0);

    // Unmapped address from master 1.
    pend[1]  = 1'b1;
    paddr[1] = 32'h0000_4000;
    txn(0, 0, 1);
    #1;
    chk("err_back_idle", 128'(m_rvalid), 128'(0));
    @(negedge clk);

    // Two masters holding arvalid: alternate service.
    refill   = 1'b1;
    pend[0]  = 1'b1;
    pend[1]  = 1'b1;
    paddr[0] = 32'h0000_0010;
    paddr[1] = 32'h0000_2020;
    for (int t = 0; t < 4; t++) txn(0, 0, 0);
    refill  = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_m();

    // Backpressure on both AR and R.
    pend[1]  = 1'b1;
    paddr[1] = 32'h0000_3010;
    txn(3, 1, 2);

    // Region edges.
    pend[0] = 1'b1; paddr[0] = 32'h0000_0FFF; txn(0, 0, 0);
    pend[0] = 1'b1; paddr[0] = 32'h0000_1000; txn(1, 0, 0);
    pend[1] = 1'b1; paddr[1] = 32'h0000_3FFF; txn(0, 2, 0);
    pend[0] = 1'b1; paddr[0] = 32'h0000_2FFF; txn(0, 0, 1);

    // Reset while master 0 waits in DATA.
    pend[0]  = 1'b1;
    paddr[0] = 32'h0000_2008;
    drive_m();
    #1;
    chk("mid_ar_grant", 128'(m_arready), 128'(1) << rr_pick());
    @(negedge clk);
    pend[0] = 1'b0;
    drive_m();
    s_arready = 4'b0100;
    #1;
    chk("mid_sarvalid", 128'(s_arvalid), 128'(4'b0100));
    @(negedge clk);
    s_arready = '0;
    s_rvalid  = 4'b0100;
    #1;
    chk("mid_rvalid", 128'(m_rvalid), 128'(2'b01));
    #1;
    m_rready = 2'b01;
    rst      = 1'b1;
    #1;
    chk_quiet("mid_rst");
    @(negedge clk);
    s_rvalid = '0;
    m_rready = '0;
    rst      = 1'b0;
    last_g   = N - 1;
    @(negedge clk);
    pend[0]  = 1'b1;
    pend[1]  = 1'b1;
    paddr[0] = 32'h0000_0100;
    paddr[1] = 32'h0000_1100;
    txn(0, 0, 0);
    txn(0, 0, 0);

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          paddr[i] = rand_addr();
        end
      end
      if (rr_pick() < 0) begin
        pend[t % N]  = 1'b1;
        paddr[t % N] = rand_addr();
      end
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
